ysyx_24100012_regfile_sb: RTL and testbench

//  Parametrised GPR file for the NPC core: N_RD combinational read ports, one write port, optional same-cycle write->read bypass.

---
 rtl/ysyx_24100012_regfile_sb_if.sv | 35 +++
 rtl/ysyx_24100012_regfile_sb.sv | 125 ++++++++++++
 tb/tb_ysyx_24100012_regfile_sb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100012_regfile_sb_if.sv
// Register-file bus between decode/writeback (master) and the GPR file (slave).
// Signals:
//   init_req  - request re-initialisation of the whole register file
//   flush     - clear every busy bit, data kept
//   wen/widx/wdata       - writeback write port
//   alloc_en/alloc_idx   - mark a destination register busy at issue
//   ridx/rdata/rbusy     - N_RD packed read ports (port k at slice k)
//   ready     - register file is initialised and serving requests
interface ysyx_24100012_regfile_sb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INDEX_LEN  = 5,
    parameter int unsigned N_RD       = 2
);
    logic                         init_req;
    logic                         flush;
    logic                         wen;
    logic [INDEX_LEN-1:0]         widx;
    logic [DATA_WIDTH-1:0]        wdata;
    logic                         alloc_en;
    logic [INDEX_LEN-1:0]         alloc_idx;
    logic [N_RD*INDEX_LEN-1:0]    ridx;
    logic [N_RD*DATA_WIDTH-1:0]   rdata;
    logic [N_RD-1:0]              rbusy;
    logic                         ready;

    modport master (
        output init_req, flush, wen, widx, wdata, alloc_en, alloc_idx, ridx,
        input  rdata, rbusy, ready
    );

    modport slave (
        input  init_req, flush, wen, widx, wdata, alloc_en, alloc_idx, ridx,
        output rdata, rbusy, ready
    );
endinterface

// File: rtl/ysyx_24100012_regfile_sb.sv
// GPR file with per-register scoreboard and flush support.
// Storage is not reset; after reset (or init_req) an INIT sequencer clears
// registers 1..N_REG-1, one per clock, so the array can map onto LUTRAM/SRAM.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - slave side of ysyx_24100012_regfile_sb_if (reads, write, alloc,
//          flush, init_req, ready)
module ysyx_24100012_regfile_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_REG      = 32,
    parameter int unsigned INDEX_LEN  = 5,
    parameter int unsigned N_RD       = 2,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    ysyx_24100012_regfile_sb_if.slave bus
);

    localparam int unsigned AW = (N_REG > 1) ? $clog2(N_REG) : 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [N_REG-1:0]      busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] mem_q [N_REG];

    logic                  run;
    logic                  live;
    logic                  we;
    logic                  ae;
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         aaddr;

    // Architectural, writable index: not x0 and inside the implemented range.
    function automatic logic idx_ok(input logic [INDEX_LEN-1:0] idx);
        return (idx != '0) && (32'(idx) < N_REG);
    endfunction

    // init_req wins over every other request of the same cycle.
    assign run   = (state_q == S_RUN);
    assign live  = run && !bus.init_req;
    assign we    = live && bus.wen && idx_ok(bus.widx);
    assign ae    = live && bus.alloc_en && idx_ok(bus.alloc_idx);
    assign waddr = bus.widx[AW-1:0];
    assign aaddr = bus.alloc_idx[AW-1:0];

    // Next-state: init sequencer, RUN control and scoreboard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(N_REG - 1)) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else if (bus.init_req) begin
            state_d = S_INIT;
            cnt_d   = AW'(1);
            busy_d  = '0;
            ready_d = 1'b0;
        end else if (bus.flush) begin
            busy_d = '0;
        end else begin
            // Release first, then alloc, so a new producer on the same index wins.
            if (we) busy_d[waddr] = 1'b0;
            if (ae) busy_d[aaddr] = 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Storage array: no reset, cleared by the INIT sequencer. Entry 0 is never read.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (we) begin
            mem_q[waddr] <= bus.wdata;
        end
    end

    // Combinational read ports with optional write-through bypass.
    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            logic [INDEX_LEN-1:0] ri;
            ri = bus.ridx[k*INDEX_LEN +: INDEX_LEN];
            if (run && idx_ok(ri)) begin
                if (BYPASS && we && (bus.widx == ri)) begin
                    bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
                    bus.rbusy[k]                          = 1'b0;
                end else begin
                    bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ri[AW-1:0]];
                    bus.rbusy[k]                          = busy_q[ri[AW-1:0]];
                end
            end
        end
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_ysyx_24100012_regfile_sb.sv
// Bench for ysyx_24100012_regfile_sb: three instances (32 regs bypass,
// 32 regs no bypass, 16 regs bypass) share one directed stimulus; a
// behavioural model is compared against every instance each cycle.
module tb_ysyx_24100012_regfile_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        init_req, flush, wen, alloc_en;
    logic [4:0]  widx, alloc_idx;
    logic [31:0] wdata;
    logic [9:0]  ridx;

    ysyx_24100012_regfile_sb_if ifa ();
    ysyx_24100012_regfile_sb_if ifb ();
    ysyx_24100012_regfile_sb_if ifc ();

    assign ifa.init_req = init_req;  assign ifb.init_req = init_req;  assign ifc.init_req = init_req;
    assign ifa.flush = flush;        assign ifb.flush = flush;        assign ifc.flush = flush;
    assign ifa.wen = wen;            assign ifb.wen = wen;            assign ifc.wen = wen;
    assign ifa.widx = widx;          assign ifb.widx = widx;          assign ifc.widx = widx;
    assign ifa.wdata = wdata;        assign ifb.wdata = wdata;        assign ifc.wdata = wdata;
    assign ifa.alloc_en = alloc_en;  assign ifb.alloc_en = alloc_en;  assign ifc.alloc_en = alloc_en;
    assign ifa.alloc_idx = alloc_idx; assign ifb.alloc_idx = alloc_idx; assign ifc.alloc_idx = alloc_idx;
    assign ifa.ridx = ridx;          assign ifb.ridx = ridx;          assign ifc.ridx = ridx;

    ysyx_24100012_regfile_sb #(.N_REG(32), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    ysyx_24100012_regfile_sb #(.N_REG(32), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    ysyx_24100012_regfile_sb #(.N_REG(16), .BYPASS(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [63:0] rd  [3];
    logic [1:0]  rb  [3];
    logic        rdy [3];
    assign rd[0] = ifa.rdata;  assign rb[0] = ifa.rbusy;  assign rdy[0] = ifa.ready;
    assign rd[1] = ifb.rdata;  assign rb[1] = ifb.rbusy;  assign rdy[1] = ifb.ready;
    assign rd[2] = ifc.rdata;  assign rb[2] = ifc.rbusy;  assign rdy[2] = ifc.ready;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned nreg [3] = '{32, 32, 16};
    bit          byp  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mmem  [3][32];
    bit          mbusy [3][32];
    int          mleft [3];   // clocks of initialisation still to go; 0 = running

    function automatic bit vidx(input logic [4:0] i, input int unsigned n);
        return (i != 5'd0) && (32'(i) < n);
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (rst !== 1'b1) begin
                mleft[c] <= int'(nreg[c]) - 1;
                for (int i = 0; i < 32; i++) mbusy[c][i] <= 1'b0;
            end else if (mleft[c] > 0) begin
                mleft[c] <= mleft[c] - 1;
                if (mleft[c] == 1)
                    for (int i = 0; i < 32; i++) mmem[c][i] <= 32'd0;
            end else if (init_req) begin
                mleft[c] <= int'(nreg[c]) - 1;
                for (int i = 0; i < 32; i++) mbusy[c][i] <= 1'b0;
            end else begin
                if (wen && vidx(widx, nreg[c])) mmem[c][widx] <= wdata;
                if (flush) begin
                    for (int i = 0; i < 32; i++) mbusy[c][i] <= 1'b0;
                end else begin
                    if (wen && vidx(widx, nreg[c])) mbusy[c][widx] <= 1'b0;
                    if (alloc_en && vidx(alloc_idx, nreg[c])) mbusy[c][alloc_idx] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] ri);
        if (mleft[c] != 0 || !vidx(ri, nreg[c])) return 32'd0;
        if (byp[c] && wen && !init_req && widx == ri) return wdata;
        return mmem[c][ri];
    endfunction

    function automatic logic exp_rb(input int c, input logic [4:0] ri);
        if (mleft[c] != 0 || !vidx(ri, nreg[c])) return 1'b0;
        if (byp[c] && wen && !init_req && widx == ri) return 1'b0;
        return mbusy[c][ri];
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("ready dut%0d", c), 32'(rdy[c]), 32'(mleft[c] == 0));
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("rdata dut%0d port%0d", c, k),
                        rd[c][k*32 +: 32], exp_rd(c, ridx[k*5 +: 5]));
                    chk($sformatf("rbusy dut%0d port%0d", c, k),
                        32'(rb[c][k]), 32'(exp_rb(c, ridx[k*5 +: 5])));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init_req = 1'b0; flush = 1'b0; wen = 1'b0; alloc_en = 1'b0;
        widx = 5'd0; alloc_idx = 5'd0; wdata = 32'd0; ridx = 10'd0;
    endtask

    task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1);
        ridx = {r1, r0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int fa, fb, fc;

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Initialisation latency after reset release.
        fa = 0; fb = 0; fc = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (rdy[0] && fa == 0) fa = n;
            if (rdy[1] && fb == 0) fb = n;
            if (rdy[2] && fc == 0) fc = n;
            if (fa != 0 && fb != 0 && fc != 0) break;
        end
        chk("reset_latency dut0", 32'(fa), 32'd31);
        chk("reset_latency dut1", 32'(fb), 32'd31);
        chk("reset_latency dut2", 32'(fc), 32'd15);

        // Every index reads zero and not busy.
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            tick();
        end

        // Write with same-cycle read of the written register.
        set_rd(5'd5, 5'd0);
        wen = 1'b1; widx = 5'd5; wdata = 32'hDEADBEEF;
        #2;
        chk("bypass_same dut0", rd[0][31:0], 32'hDEADBEEF);
        chk("nobypass_same dut1", rd[1][31:0], 32'h0);
        tick();
        wen = 1'b0;
        #2;
        chk("write_next dut0", rd[0][31:0], 32'hDEADBEEF);
        chk("write_next dut1", rd[1][31:0], 32'hDEADBEEF);
        tick();

        // x0 is hardwired: write and alloc have no effect.
        wen = 1'b1; widx = 5'd0; wdata = 32'h1234; alloc_en = 1'b1; alloc_idx = 5'd0;
        set_rd(5'd0, 5'd0);
        tick();
        idle(); set_rd(5'd0, 5'd0);
        #2;
        chk("x0_data dut0", rd[0][31:0], 32'h0);
        chk("x0_busy dut0", 32'(rb[0][0]), 32'd0);
        tick();

        // Alloc/release interplay on x7.
        alloc_en = 1'b1; alloc_idx = 5'd7; set_rd(5'd7, 5'd0);
        #2;
        chk("alloc_same_cycle dut0", 32'(rb[0][0]), 32'd0);
        tick();
        idle(); set_rd(5'd7, 5'd0);
        #2;
        chk("alloc_next dut0", 32'(rb[0][0]), 32'd1);
        wen = 1'b1; widx = 5'd7; wdata = 32'h77; alloc_en = 1'b1; alloc_idx = 5'd7;
        tick();
        idle(); set_rd(5'd7, 5'd0);
        #2;
        chk("alloc_wins dut0", 32'(rb[0][0]), 32'd1);
        chk("alloc_wins_data dut0", rd[0][31:0], 32'h77);
        wen = 1'b1; widx = 5'd7; wdata = 32'h99;
        tick();
        idle(); set_rd(5'd7, 5'd0);
        #2;
        chk("release dut0", 32'(rb[0][0]), 32'd0);
        chk("release_data dut0", rd[0][31:0], 32'h99);
        chk("release dut1", 32'(rb[1][0]), 32'd0);
        tick();

        // Flush clears busy, drops a concurrent alloc, keeps the write.
        alloc_en = 1'b1; alloc_idx = 5'd3;
        tick();
        alloc_idx = 5'd9;
        tick();
        idle(); set_rd(5'd3, 5'd9);
        #2;
        chk("busy_before_flush dut0", 32'(rb[0]), 32'd3);
        flush = 1'b1; wen = 1'b1; widx = 5'd3; wdata = 32'h55;
        alloc_en = 1'b1; alloc_idx = 5'd9;
        tick();
        idle(); set_rd(5'd3, 5'd9);
        #2;
        chk("busy_after_flush dut0", 32'(rb[0]), 32'd0);
        chk("flush_write dut0", rd[0][31:0], 32'h55);
        chk("flush_keep dut0", rd[0][63:32], 32'h0);
        tick();

        // Out-of-range index on the 16-register instance.
        set_rd(5'd20, 5'd0);
        wen = 1'b1; widx = 5'd20; wdata = 32'hABCD;
        alloc_en = 1'b1; alloc_idx = 5'd20;
        #2;
        chk("oor_read dut2", rd[2][31:0], 32'h0);
        tick();
        idle(); set_rd(5'd20, 5'd0);
        #2;
        chk("oor_after dut2", rd[2][31:0], 32'h0);
        chk("oor_busy dut2", 32'(rb[2][0]), 32'd0);
        chk("inrange_write dut0", rd[0][31:0], 32'hABCD);
        tick();

        // Re-initialisation from RUN; the concurrent write is dropped.
        init_req = 1'b1; wen = 1'b1; widx = 5'd5; wdata = 32'h1111;
        tick();
        idle();
        #2;
        chk("init_ready_low dut2", 32'(rdy[2]), 32'd0);
        fa = 0; fc = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (rdy[0] && fa == 0) fa = n;
            if (rdy[2] && fc == 0) fc = n;
            if (fa != 0 && fc != 0) break;
        end
        chk("reinit_latency dut0", 32'(fa), 32'd31);
        chk("reinit_latency dut2", 32'(fc), 32'd15);
        set_rd(5'd5, 5'd7);
        #2;
        chk("reinit_zero x5 dut0", rd[0][31:0], 32'h0);
        chk("reinit_zero x7 dut0", rd[0][63:32], 32'h0);
        chk("reinit_busy dut0", 32'(rb[0]), 32'd0);
        tick();
        set_rd(5'd3, 5'd15);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
